apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
Two-requester APB master. Shares the single APB peripheral bus (I2C, SPI, PWM32, TIMER32 slaves behind the APB bus decoder) between requester 0 (bridge-side master) and requester 1 (secondary master, e.g. a DMA/sequencer engine). Uses round-robin arbitration and generates compliant APB SETUP/ACCESS phases. Adds a PREADY timeout so a hung slave cannot lock the bus.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT, 255, maximum ACCESS cycles waiting for PREADY; 0 disables timeout

Ports:
clk  in  1  clock (same clock as PCLK domain)
rst  in  1  synchronous reset, active-high
req0_i  in  1  requester 0 transfer request, level, held until done0_o
addr0_i  in  ADDR_W  requester 0 address
write0_i  in  1  requester 0: 1 = write, 0 = read
wdata0_i  in  DATA_W  requester 0 write data
done0_o  out  1  one-cycle pulse, requester 0 transfer complete
err0_o  out  1  valid with done0_o; PSLVERR or timeout
req1_i, addr1_i, write1_i, wdata1_i, done1_o, err1_o  as above, requester 1
rdata_o  out  DATA_W  read data, valid with either done pulse
PADDR  out  ADDR_W  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; PSEL, PENABLE, PWRITE, done*, err* = 0; PADDR, PWDATA, rdata_o = 0; last_grant=1, so requester 0 wins the first tie; timeout counter=0. Reset mid-transfer aborts immediately. No done pulse is issued.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible request: reqK_i=1 and doneK_o=0. Masking prevents re-grant in the cycle the requester sees its done.
  - One eligible: grant it.
  - Both eligible: grant the requester != last_grant.
  - On grant: latch addr/write/wdata of the winner into PADDR/PWRITE/PWDATA, set last_grant, go to SETUP.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable.
  - At an edge with PREADY=1:
    - Next cycle: doneK_o=1 for the granted K; errK_o=PSLVERR.
    - rdata_o = PRDATA on reads; unchanged on writes.
    - PSEL=0, PENABLE=0; go to IDLE.
- Timeout (TIMEOUT>0):
  - Counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT, terminate as a completion: doneK_o=1, errK_o=1, rdata_o=0, go to IDLE.
  - Counter width is clog2(TIMEOUT+1).
  - TIMEOUT=0: wait indefinitely.
- Latency: reqK_i rising in IDLE at cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> with zero wait states, doneK_o in cycle 3. One IDLE cycle minimum between transfers (done cycle = IDLE).
- done/err outputs are registered; exactly one done pulse per granted transfer.
- Inputs changing after grant are ignored; the transfer uses the latched values.
- Requester dropping reqK_i mid-transfer: the transfer still completes and done still pulses.
- err*_o=0 whenever the corresponding done*_o=0.
- PSEL never asserted without a grant; PENABLE never high without PSEL.

Test Plan:
- Single read, zero wait:
  - Stimulus: req0 with addr0=0x0030_0004, write0=0; PREADY=1, PRDATA=0xDEAD_BEEF.
  - Response: PSEL cycle 1, PENABLE cycle 2, done0 cycle 3, rdata_o=0xDEAD_BEEF, err0=0.
- Write with 3 wait states:
  - Stimulus: req1 write, addr1=0x0020_0000, wdata1=0x0000_00FF; PREADY low 3 ACCESS cycles.
  - Response: PADDR/PWDATA stable throughout ACCESS, done1 in cycle 6, rdata_o unchanged.
- Simultaneous requests, both held:
  - First pass after reset: grants alternate 0,1,0,1 over four transfers.
  - No back-to-back grant to the same requester while the other is pending.
- Slave error:
  - Stimulus: PSLVERR=1 with PREADY=1 on a req0 read.
  - Response: done0=1, err0=1.
- Timeout:
  - Stimulus: TIMEOUT=4, PREADY held 0.
  - Response: done=1, err=1, rdata_o=0 after 4 ACCESS cycles; PSEL drops the next cycle; next pending request is served.
- Reset mid-ACCESS:
  - Stimulus: assert rst.
  - Response: next cycle PSEL=PENABLE=0, no done pulse; after release, a held req0 is granted first.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin two-requester APB master with PREADY timeout
module apb_master_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic              write0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              done0_o,
  output logic              err0_o,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic              write1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              done1_o,
  output logic              err1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, state_n;
  logic last_grant, gnt, e0, e1, pick, tout, fin, ferr;
  logic [CW-1:0] cnt;
  assign PSEL    = state != IDLE;
  assign PENABLE = state == ACCESS;
  // arbitration, completion detection and next state
  always_comb begin
    e0      = req0_i & ~done0_o;
    e1      = req1_i & ~done1_o;
    pick    = (e0 & e1) ? ~last_grant : e1;
    tout    = (TIMEOUT > 0) && !PREADY && cnt == CW'(TIMEOUT - 1);
    fin     = state == ACCESS && (PREADY || tout);
    ferr    = PREADY ? PSLVERR : 1'b1;
    state_n = state == IDLE  ? ((e0 | e1) ? SETUP : IDLE) :
              state == SETUP ? ACCESS : (fin ? IDLE : ACCESS);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // grant latch, bus fields, wait counter and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      rdata_o    <= '0;
      cnt        <= '0;
      done0_o    <= 1'b0;
      done1_o    <= 1'b0;
      err0_o     <= 1'b0;
      err1_o     <= 1'b0;
    end else begin
      done0_o <= fin & ~gnt;
      done1_o <= fin & gnt;
      err0_o  <= fin & ~gnt & ferr;
      err1_o  <= fin & gnt & ferr;
      cnt     <= state == SETUP ? '0 : (state == ACCESS && !PREADY) ? cnt + CW'(1) : cnt;
      if (state == IDLE && (e0 | e1)) begin
        gnt        <= pick;
        last_grant <= pick;
        PADDR      <= pick ? addr1_i : addr0_i;
        PWRITE     <= pick ? write1_i : write0_i;
        PWDATA     <= pick ? wdata1_i : wdata0_i;
      end
      if (fin && (!PREADY || !PWRITE)) rdata_o <= PREADY ? PRDATA : '0;
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed-vector bench for apb_master_arbiter
module tb_apb_master_arbiter;
  logic clk = 0, rst = 1;
  logic req0 = 0, write0 = 0, req1 = 0, write1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic done0, err0, done1, err1, psel, penable, pwrite;
  logic [31:0] rdata, paddr, pwdata;
  logic [31:0] prdata = 0;
  logic pready = 1, pslverr = 0;
  int vecs = 0, errs = 0;
  apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .addr0_i(addr0), .write0_i(write0), .wdata0_i(wdata0),
    .done0_o(done0), .err0_o(err0),
    .req1_i(req1), .addr1_i(addr1), .write1_i(write1), .wdata1_i(wdata1),
    .done1_o(done1), .err1_o(err1),
    .rdata_o(rdata), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick(); tick();
    chk("rst_psel", psel, 0);
    chk("rst_pen", penable, 0);
    chk("rst_done0", done0, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rdata", rdata, 0);
    rst = 0;
    // single read, zero wait
    req0 = 1; addr0 = 32'h0030_0004; write0 = 0; pready = 1; prdata = 32'hDEAD_BEEF;
    tick();
    chk("rd_c1_psel", psel, 1);
    chk("rd_c1_pen", penable, 0);
    chk("rd_c1_paddr", paddr, 32'h0030_0004);
    tick();
    chk("rd_c2_pen", penable, 1);
    tick();
    chk("rd_c3_done0", done0, 1);
    chk("rd_c3_err0", err0, 0);
    chk("rd_c3_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd_c3_psel", psel, 0);
    req0 = 0;
    tick();
    chk("rd_c4_done0", done0, 0);
    // write, three wait states
    req1 = 1; addr1 = 32'h0020_0000; wdata1 = 32'h0000_00FF; write1 = 1; pready = 0;
    tick(); tick();
    chk("wr_c2_pwrite", pwrite, 1);
    chk("wr_c2_pwdata", pwdata, 32'h0000_00FF);
    addr1 = 32'h1111_1111; wdata1 = 32'h2222_2222;
    tick(); tick();
    chk("wr_c4_paddr", paddr, 32'h0020_0000);
    chk("wr_c4_pwdata", pwdata, 32'h0000_00FF);
    chk("wr_c4_pen", penable, 1);
    chk("wr_c4_done1", done1, 0);
    tick();
    pready = 1;
    tick();
    chk("wr_c6_done1", done1, 1);
    chk("wr_c6_err1", err1, 0);
    chk("wr_c6_rdata", rdata, 32'hDEAD_BEEF);
    req1 = 0; write1 = 0;
    // round robin after reset, both held
    rst = 1; tick(); rst = 0;
    addr0 = 32'h100; addr1 = 32'h200; req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr%0d_setup", i), {psel, penable}, 2'b10);
      chk($sformatf("rr%0d_paddr", i), paddr, i % 2 ? 32'h200 : 32'h100);
      tick(); tick();
      chk($sformatf("rr%0d_done", i), {done1, done0}, i % 2 ? 2'b10 : 2'b01);
    end
    req0 = 0; req1 = 0;
    // slave error
    tick();
    req0 = 1; addr0 = 32'h0010_0008; pslverr = 1;
    tick(); tick(); tick();
    chk("se_done0", done0, 1);
    chk("se_err0", err0, 1);
    req0 = 0; pslverr = 0;
    tick();
    chk("se_err0_clr", err0, 0);
    // timeout with a second requester pending
    pready = 0; req0 = 1; req1 = 1; addr0 = 32'h0040_0000; addr1 = 32'h0050_0000;
    tick();
    chk("to_grant1", paddr, 32'h0050_0000);
    tick(); tick(); tick(); tick();
    chk("to_c5_psel", psel, 1);
    chk("to_c5_done1", done1, 0);
    tick();
    chk("to_c6_done1", done1, 1);
    chk("to_c6_err1", err1, 1);
    chk("to_c6_rdata", rdata, 0);
    chk("to_c6_psel", psel, 0);
    req1 = 0; pready = 1;
    tick();
    chk("to_c7_paddr", paddr, 32'h0040_0000);
    chk("to_c7_psel", psel, 1);
    tick(); tick();
    chk("to_c9_done0", done0, 1);
    chk("to_c9_err0", err0, 0);
    req0 = 0;
    // reset mid-access
    tick();
    req0 = 1; addr0 = 32'h0060_0000; pready = 0;
    tick(); tick();
    chk("ra_pen", penable, 1);
    rst = 1; req1 = 1; addr1 = 32'h0070_0000;
    tick();
    chk("ra_psel", psel, 0);
    chk("ra_pen0", penable, 0);
    chk("ra_done0", done0, 0);
    rst = 0;
    tick();
    chk("ra_regrant", paddr, 32'h0060_0000);
    chk("ra_done0_b", done0, 0);
    req0 = 0; req1 = 0; pready = 1;
    tick(); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
